video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Pixel-timing generator that sits directly upstream of the paddle and ball objects and of the pixel mixer. Produces signed raster coordinates, sync/data-enable for the HDMI encoder, and the once-per-frame fsync strobe that objects use to update position. Blanking is mapped to negative coordinates so the active area is always hpos 0..HRES-1, vpos 0..VRES-1.

Parameters:
HRES, 1280, active pixels per line
HFP, 110, horizontal front porch (pixels)
HSW, 40, hsync width (pixels)
HBP, 220, horizontal back porch (pixels)
VRES, 720, active lines per frame
VFP, 5, vertical front porch (lines)
VSW, 5, vsync width (lines)
VBP, 20, vertical back porch (lines)
HSYNC_POL, 1, asserted level of hsync
VSYNC_POL, 1, asserted level of vsync

Ports:
pixel_clk  in  1  pixel clock (74.25 MHz for 720p60)
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable (tie to MMCM locked); holds timing when low
hpos  out  12 signed  horizontal coordinate, -HBLANK..HRES-1
vpos  out  12 signed  vertical coordinate, -VBLANK..VRES-1
hsync  out  1  horizontal sync, polarity HSYNC_POL
vsync  out  1  vertical sync, polarity VSYNC_POL
de  out  1  data enable, high when hpos>=0 and vpos>=0
fsync  out  1  one-cycle start-of-frame-blanking strobe

Behaviour:
- HBLANK=HFP+HSW+HBP (370), VBLANK=VFP+VSW+VBP (30); line = 1650 clocks, frame = 750 lines.
- Line order: front porch hpos -370..-261, sync -260..-221, back porch -220..-1, active 0..1279. Vertical same pattern in lines: FP -30..-26, sync -25..-21, BP -20..-1, active 0..719.
- All outputs registered; decoded outputs align with the hpos/vpos shown in the same cycle (zero skew).
- Reset (async assert, sync deassert externally): hpos=-HBLANK, vpos=-VBLANK, hsync=vsync=!POL, de=0, fsync=0.
- en=1: hpos increments each clock; at HRES-1 wraps to -HBLANK and vpos increments; vpos at VRES-1 with hpos wrap goes to -VBLANK.
- en=0: all counters and hsync/vsync/de hold; fsync forced 0. Resumes at next count with no skipped pixel.
- hsync asserted while hpos in [-HBLANK+HFP, -HBP-1]; vsync asserted over all clocks of lines vpos in [-VBLANK+VFP, -VBP-1].
- fsync=1 for exactly the one cycle where outputs show hpos=-HBLANK, vpos=-VBLANK, entered by count (not by reset); first fsync therefore one full frame (1,237,500 clocks) after reset release.
- Widths: parameters must satisfy HRES+HBLANK<=2047 and VRES+VBLANK<=2047; elaboration error otherwise.

Optional Feature:
VTG_FRAME_COUNT_EN: when defined, adds output frame_cnt [15:0], reset 0, incremented in the cycle fsync asserts, wraps 65535->0. Without it, port absent and no counter logic.

Decomposition:
- Package video_timing_pkg: 720p default constants, coordinate width (12), signed coordinate typedef, blanking-derived localparams.
- Sub-module vtg_axis_counter: signed wrap counter with parameters ACTIVE/FP/SW/BP, inputs inc, outputs pos, sync, active, wrap; instantiated once for h (inc=en) and once for v (inc=en & h wrap).

Test Plan:
- Reset then en=1 for 1650 clocks -> hpos -370..1279 then back to -370, vpos -30 -> -29; hsync high exactly 40 clocks starting at hpos=-260.
- Run one full frame -> fsync pulses once, 1,237,500 clocks after reset release, with hpos=-370, vpos=-30; de high for exactly 921,600 clocks.
- en dropped for 10 clocks at hpos=100 -> hpos holds 100, fsync stays 0, next enabled cycle shows 101.
- rst_n asserted mid-frame (vpos=400) -> immediately hpos=-370, vpos=-30, de=0, syncs deasserted, fsync=0.
- Parameter override 640x480 (HFP16,HSW96,HBP48,VFP10,VSW2,VBP33), HSYNC_POL=0 -> 800x525 totals, hsync low 96 clocks per line.
- With VTG_FRAME_COUNT_EN, 3 frames -> frame_cnt 0->1->2->3, each step coincident with fsync.

Source files
------------

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared 720p defaults, coordinate type and blanking constants for the timing generator
package video_timing_pkg;

  localparam int COORD_W   = 12;
  localparam int COORD_MAX = 2047;

  typedef logic signed [COORD_W-1:0] coord_t;

  localparam int DEF_HRES = 1280;
  localparam int DEF_HFP  = 110;
  localparam int DEF_HSW  = 40;
  localparam int DEF_HBP  = 220;
  localparam int DEF_VRES = 720;
  localparam int DEF_VFP  = 5;
  localparam int DEF_VSW  = 5;
  localparam int DEF_VBP  = 20;

  function automatic int blank_len(input int fp, input int sw, input int bp);
    return fp + sw + bp;
  endfunction

  localparam int DEF_HBLANK = blank_len(DEF_HFP, DEF_HSW, DEF_HBP);
  localparam int DEF_VBLANK = blank_len(DEF_VFP, DEF_VSW, DEF_VBP);

endpackage

// File: rtl/vtg_axis_counter.sv
// rtl/vtg_axis_counter.sv - signed raster counter for one axis: -BLANK..ACTIVE-1 with registered sync flag
module vtg_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_HRES,
  parameter int FP     = DEF_HFP,
  parameter int SW     = DEF_HSW,
  parameter int BP     = DEF_HBP
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  output coord_t pos,
  output logic   sync,
  output logic   active_next,
  output logic   wrap
);

  localparam int     BLANK   = blank_len(FP, SW, BP);
  localparam coord_t FIRST   = coord_t'(-BLANK);
  localparam coord_t LAST    = coord_t'(ACTIVE - 1);
  localparam coord_t SYNC_LO = coord_t'(FP - BLANK);
  localparam coord_t SYNC_HI = coord_t'(-BP - 1);

  coord_t pos_next;

  always_comb begin
    wrap     = inc && (pos == LAST);
    pos_next = pos;
    if (wrap)
      pos_next = FIRST;
    else if (inc)
      pos_next = pos + coord_t'(1);
  end

  // Decoded flags are computed from the next position so they line up with pos.
  assign active_next = ~pos_next[COORD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= FIRST;
      sync <= 1'b0;
    end else if (inc) begin
      pos  <= pos_next;
      sync <= (pos_next >= SYNC_LO) && (pos_next <= SYNC_HI);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator (coords, syncs, de, fsync); VTG_FRAME_COUNT_EN adds frame_cnt
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HRES      = DEF_HRES,
  parameter int HFP       = DEF_HFP,
  parameter int HSW       = DEF_HSW,
  parameter int HBP       = DEF_HBP,
  parameter int VRES      = DEF_VRES,
  parameter int VFP       = DEF_VFP,
  parameter int VSW       = DEF_VSW,
  parameter int VBP       = DEF_VBP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic   pixel_clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t hpos,
  output coord_t vpos,
  output logic   hsync,
  output logic   vsync,
  output logic   de,
  output logic   fsync
`ifdef VTG_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int HBLANK = blank_len(HFP, HSW, HBP);
  localparam int VBLANK = blank_len(VFP, VSW, VBP);

  if (HRES + HBLANK > COORD_MAX) begin : g_hres_check
    $error("video_timing_gen: HRES+HBLANK exceeds coordinate range");
  end
  if (VRES + VBLANK > COORD_MAX) begin : g_vres_check
    $error("video_timing_gen: VRES+VBLANK exceeds coordinate range");
  end

  logic h_sync, v_sync, h_wrap, v_wrap, h_act_next, v_act_next;

  vtg_axis_counter #(.ACTIVE(HRES), .FP(HFP), .SW(HSW), .BP(HBP)) u_hcnt (
    .clk         (pixel_clk),
    .rst_n       (rst_n),
    .inc         (en),
    .pos         (hpos),
    .sync        (h_sync),
    .active_next (h_act_next),
    .wrap        (h_wrap)
  );

  vtg_axis_counter #(.ACTIVE(VRES), .FP(VFP), .SW(VSW), .BP(VBP)) u_vcnt (
    .clk         (pixel_clk),
    .rst_n       (rst_n),
    .inc         (en & h_wrap),
    .pos         (vpos),
    .sync        (v_sync),
    .active_next (v_act_next),
    .wrap        (v_wrap)
  );

  assign hsync = HSYNC_POL ? h_sync : ~h_sync;
  assign vsync = VSYNC_POL ? v_sync : ~v_sync;

  // Vertical wrap only fires on an enabled last pixel of the last line: the next cycle is frame start.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      de    <= 1'b0;
      fsync <= 1'b0;
    end else begin
      fsync <= v_wrap;
      if (en)
        de <= h_act_next & v_act_next;
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= 16'd0;
    else if (v_wrap)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - bench for video_timing_gen at 720p, a tiny raster and 640x480
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic signed [11:0] hpos_a, vpos_a, hpos_b, vpos_b, hpos_c, vpos_c;
  logic hsync_a, vsync_a, de_a, fsync_a;
  logic hsync_b, vsync_b, de_b, fsync_b;
  logic hsync_c, vsync_c, de_c, fsync_c;
  logic [15:0] fc_a, fc_b, fc_c;

  int errors = 0;
  int checks = 0;

  video_timing_gen dut_a (
    .pixel_clk(clk), .rst_n(rst_a), .en(en_a), .hpos(hpos_a), .vpos(vpos_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .fsync(fsync_a)
`ifdef VTG_FRAME_COUNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  video_timing_gen #(.HRES(8), .HFP(2), .HSW(3), .HBP(2), .VRES(4), .VFP(1), .VSW(2), .VBP(1),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)) dut_b (
    .pixel_clk(clk), .rst_n(rst_b), .en(en_b), .hpos(hpos_b), .vpos(vpos_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .fsync(fsync_b)
`ifdef VTG_FRAME_COUNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  video_timing_gen #(.HRES(640), .HFP(16), .HSW(96), .HBP(48), .VRES(480), .VFP(10), .VSW(2), .VBP(33),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)) dut_c (
    .pixel_clk(clk), .rst_n(rst_c), .en(en_c), .hpos(hpos_c), .vpos(vpos_c),
    .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .fsync(fsync_c)
`ifdef VTG_FRAME_COUNT_EN
    , .frame_cnt(fc_c)
`endif
  );

`ifndef VTG_FRAME_COUNT_EN
  assign fc_a = 16'd0;
  assign fc_b = 16'd0;
  assign fc_c = 16'd0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: n enabled pixel clocks since reset fully determine the raster position.
  task automatic cmp_dut(input string tag, input int n, input bit le,
                         input int hr, input int hf, input int hs, input int hb,
                         input int vr, input int vf, input int vs, input int vb,
                         input bit hp, input bit vp,
                         input int ah, input int av, input bit ahs, input bit avs,
                         input bit ade, input bit afs, input int afc);
    int htot, vtot, hbl, vbl, eh, ev;
    bit ehs, evs;
    hbl  = hf + hs + hb;
    vbl  = vf + vs + vb;
    htot = hr + hbl;
    vtot = vr + vbl;
    eh   = (n % htot) - hbl;
    ev   = ((n / htot) % vtot) - vbl;
    ehs  = (eh >= -hbl + hf) && (eh <= -hb - 1);
    evs  = (ev >= -vbl + vf) && (ev <= -vb - 1);
    chk({tag, ".hpos"}, ah, eh);
    chk({tag, ".vpos"}, av, ev);
    chk({tag, ".hsync"}, int'(ahs), int'(ehs ? hp : !hp));
    chk({tag, ".vsync"}, int'(avs), int'(evs ? vp : !vp));
    chk({tag, ".de"}, int'(ade), int'(eh >= 0 && ev >= 0));
    chk({tag, ".fsync"}, int'(afs), int'(le && n > 0 && (n % (htot * vtot)) == 0));
`ifdef VTG_FRAME_COUNT_EN
    chk({tag, ".frame_cnt"}, afc, (n / (htot * vtot)) % 65536);
`else
    if (afc != 0) chk({tag, ".frame_cnt_tie"}, afc, 0);
`endif
  endtask

  int na = 0, nb = 0, nc = 0;
  bit lea = 0, leb = 0, lec = 0;

  always @(posedge clk or negedge rst_a)
    if (!rst_a) begin na <= 0; lea <= 0; end
    else begin lea <= en_a; if (en_a) na <= na + 1; end
  always @(posedge clk or negedge rst_b)
    if (!rst_b) begin nb <= 0; leb <= 0; end
    else begin leb <= en_b; if (en_b) nb <= nb + 1; end
  always @(posedge clk or negedge rst_c)
    if (!rst_c) begin nc <= 0; lec <= 0; end
    else begin lec <= en_c; if (en_c) nc <= nc + 1; end

  always @(negedge clk) begin
    cmp_dut("a", na, lea, 1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1,
            int'(hpos_a), int'(vpos_a), hsync_a, vsync_a, de_a, fsync_a, int'(fc_a));
    cmp_dut("b", nb, leb, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b1,
            int'(hpos_b), int'(vpos_b), hsync_b, vsync_b, de_b, fsync_b, int'(fc_b));
    cmp_dut("c", nc, lec, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b1,
            int'(hpos_c), int'(vpos_c), hsync_c, vsync_c, de_c, fsync_c, int'(fc_c));
  end

  int hs_cnt = 0, hs_first = 9999, fs_cnt = 0, fs_at = -1, fs_h = 0, fs_v = 0, de_cnt = 0, hsl_c = 0, steps = 0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hpos", int'(hpos_a), -370);
    chk("rst_vpos", int'(vpos_a), -30);
    chk("rst_hsync", int'(hsync_a), 0);
    chk("rst_vsync", int'(vsync_a), 0);
    chk("rst_de", int'(de_a), 0);
    chk("rst_fsync", int'(fsync_a), 0);
    chk("rst_hsync_neg_pol", int'(hsync_c), 1);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    for (int i = 1; i <= 1650; i++) begin
      @(negedge clk);
      if (hsync_a) begin
        if (hs_cnt == 0) hs_first = int'(hpos_a);
        hs_cnt++;
      end
      if (i <= 120) begin
        if (fsync_b) begin fs_cnt++; fs_at = i; fs_h = int'(hpos_b); fs_v = int'(vpos_b); end
        if (de_b) de_cnt++;
      end
      if (i <= 800 && !hsync_c) hsl_c++;
      if (i == 1) chk("first_pixel", int'(hpos_a), -369);
      if (i == 1649) chk("line_last_pixel", int'(hpos_a), 1279);
    end
    chk("line_wrap_hpos", int'(hpos_a), -370);
    chk("line_wrap_vpos", int'(vpos_a), -29);
    chk("hsync_width", hs_cnt, 40);
    chk("hsync_start", hs_first, -260);
    chk("tiny_fsync_count", fs_cnt, 1);
    chk("tiny_fsync_cycle", fs_at, 120);
    chk("tiny_fsync_hpos", fs_h, -7);
    chk("tiny_fsync_vpos", fs_v, -4);
    chk("tiny_de_count", de_cnt, 32);
    chk("vga_hsync_low", hsl_c, 96);

    for (int k = 0; k < 2000 && hpos_a != 12'sd100; k++) @(negedge clk);
    chk("hold_reach", int'(hpos_a), 100);
    en_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_hpos", int'(hpos_a), 100);
      chk("hold_fsync", int'(fsync_a), 0);
    end
    en_a = 1'b1;
    @(negedge clk);
    chk("resume_hpos", int'(hpos_a), 101);

    for (int k = 0; k < 200 && vpos_b != 12'sd2; k++) @(negedge clk);
    chk("midframe_reach", int'(vpos_b), 2);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_hpos", int'(hpos_b), -7);
    chk("async_rst_vpos", int'(vpos_b), -4);
    chk("async_rst_de", int'(de_b), 0);
    chk("async_rst_hsync", int'(hsync_b), 1);
    chk("async_rst_vsync", int'(vsync_b), 0);
    chk("async_rst_fsync", int'(fsync_b), 0);
    @(negedge clk);
    rst_b = 1'b1;

    fs_cnt = 0;
    for (int i = 1; i <= 360; i++) begin
      @(negedge clk);
      if (fsync_b) begin
        fs_cnt++;
`ifdef VTG_FRAME_COUNT_EN
        steps++;
        chk("frame_cnt_step", int'(fc_b), steps);
`endif
      end
    end
    chk("three_frames_fsync", fs_cnt, 3);
`ifdef VTG_FRAME_COUNT_EN
    chk("frame_cnt_final", int'(fc_b), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
